// File: rtl/mandelbrot_engine.sv
// Fixed-point Mandelbrot raster renderer: one z <- z^2 + c iteration per clock, one plot strobe per pixel.
// Optional Julia mode (extra ports julia/jc_re/jc_im) is compiled in with `define MANDELBROT_JULIA_EN.
module mandelbrot_engine #(
  parameter int WIDTH       = 32,
  parameter int FRAC        = 22,
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int MAX_ITER    = 16,
  parameter int COLOUR_BITS = 3,
  parameter int XW          = 9,
  parameter int YW          = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_origin,
  input  logic signed [WIDTH-1:0] y_origin,
  input  logic signed [WIDTH-1:0] step,
  output logic                    busy,
  output logic                    done,
  output logic [XW-1:0]           vga_x,
  output logic [YW-1:0]           vga_y,
  output logic [COLOUR_BITS-1:0]  vga_colour,
  output logic                    vga_plot
`ifdef MANDELBROT_JULIA_EN
  ,
  input  logic                    julia,
  input  logic signed [WIDTH-1:0] jc_re,
  input  logic signed [WIDTH-1:0] jc_im
`endif
);

  localparam int DW = 2 * WIDTH;
  // 4.0 in the widened escape-test format, one guard bit above the squared magnitudes
  localparam logic signed [DW:0] C_FOUR = {{(DW-2-FRAC){1'b0}}, 3'b100, {FRAC{1'b0}}};
  localparam logic [XW-1:0] C_LAST_X = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] C_LAST_Y = YW'(SCREEN_H - 1);
  localparam logic [15:0]   C_MAX_N  = 16'(MAX_ITER);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ITER, S_PLOT, S_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [WIDTH-1:0] r_x0;
  logic signed [WIDTH-1:0] r_step;
  logic signed [WIDTH-1:0] r_cx;
  logic signed [WIDTH-1:0] r_cy;
  logic signed [WIDTH-1:0] r_a;
  logic signed [WIDTH-1:0] r_b;
  logic [XW-1:0]           r_i;
  logic [YW-1:0]           r_j;
  logic [15:0]             r_n;

  logic signed [DW-1:0]    w_a_ext;
  logic signed [DW-1:0]    w_b_ext;
  logic signed [DW-1:0]    w_sq_a;
  logic signed [DW-1:0]    w_sq_b;
  logic signed [DW-1:0]    w_prod_ab;
  logic signed [DW-1:0]    w_aa;
  logic signed [DW-1:0]    w_bb;
  logic signed [DW-1:0]    w_ab2;
  logic signed [DW:0]      w_mag;
  logic signed [WIDTH-1:0] w_add_re;
  logic signed [WIDTH-1:0] w_add_im;
  logic signed [WIDTH-1:0] w_a_next;
  logic signed [WIDTH-1:0] w_b_next;
  logic                    w_escape;
  logic                    w_n_max;
  logic                    w_last_x;
  logic                    w_last_y;
  logic                    w_unused;

`ifdef MANDELBROT_JULIA_EN
  logic                    r_julia;
  logic signed [WIDTH-1:0] r_jre;
  logic signed [WIDTH-1:0] r_jim;

  assign w_add_re = r_julia ? r_jre : r_cx;
  assign w_add_im = r_julia ? r_jim : r_cy;
`else
  assign w_add_re = r_cx;
  assign w_add_im = r_cy;
`endif

  assign w_a_ext   = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_b_ext   = {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_sq_a    = w_a_ext * w_a_ext;
  assign w_sq_b    = w_b_ext * w_b_ext;
  assign w_prod_ab = w_a_ext * w_b_ext;
  assign w_aa      = w_sq_a >>> FRAC;
  assign w_bb      = w_sq_b >>> FRAC;
  assign w_ab2     = w_prod_ab >>> (FRAC - 1);
  assign w_mag     = {w_aa[DW-1], w_aa} + {w_bb[DW-1], w_bb};
  assign w_escape  = (w_mag > C_FOUR);
  assign w_n_max   = (r_n == C_MAX_N);
  // Next z wraps at WIDTH, so only the low bits of the products matter here
  assign w_a_next  = w_aa[WIDTH-1:0] - w_bb[WIDTH-1:0] + w_add_re;
  assign w_b_next  = w_ab2[WIDTH-1:0] + w_add_im;
  assign w_last_x  = (r_i == C_LAST_X);
  assign w_last_y  = (r_j == C_LAST_Y);
  assign w_unused  = ^w_ab2[DW-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_INIT;
      S_INIT: w_state_next = S_ITER;
      S_ITER: if (w_escape || w_n_max) w_state_next = S_PLOT;
      S_PLOT: w_state_next = (w_last_x && w_last_y) ? S_DONE : S_INIT;
      S_DONE: if (!start) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      vga_plot <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x0   <= x_origin;
            r_step <= step;
            r_cx   <= x_origin;
            r_cy   <= y_origin;
            r_i    <= '0;
            r_j    <= '0;
            busy   <= 1'b1;
`ifdef MANDELBROT_JULIA_EN
            r_julia <= julia;
            r_jre   <= jc_re;
            r_jim   <= jc_im;
`endif
          end
        end
        S_INIT: begin
          r_a <= r_cx;
          r_b <= r_cy;
          r_n <= '0;
        end
        S_ITER: begin
          if (w_escape || w_n_max) begin
            vga_plot   <= 1'b1;
            vga_x      <= r_i;
            vga_y      <= r_j;
            vga_colour <= w_escape ? r_n[COLOUR_BITS-1:0] : '0;
          end else begin
            r_a <= w_a_next;
            r_b <= w_b_next;
            r_n <= r_n + 16'd1;
          end
        end
        S_PLOT: begin
          // Raster order, x fastest; coordinates advance by addition only
          if (!w_last_x) begin
            r_i  <= r_i + 1'b1;
            r_cx <= r_cx + r_step;
          end else begin
            r_i  <= '0;
            r_cx <= r_x0;
            r_j  <= r_j + 1'b1;
            r_cy <= r_cy + r_step;
            if (w_last_y) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        S_DONE: if (!start) done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_engine.sv
// Scoreboard bench for mandelbrot_engine on a 4x3 screen: a longint reference model predicts
// every plot (position, colour, cycle) and the monitor checks each strobe against the queue.
module tb_mandelbrot_engine;

  localparam int W   = 32;
  localparam int SW  = 4;
  localparam int SH  = 3;
  localparam int MI  = 16;
  localparam int ONE = 1 << 22;

  logic                clk;
  logic                rstn;
  logic                start;
  logic signed [W-1:0] x_origin;
  logic signed [W-1:0] y_origin;
  logic signed [W-1:0] step;
  logic                busy;
  logic                done;
  logic [8:0]          vga_x;
  logic [7:0]          vga_y;
  logic [2:0]          vga_colour;
  logic                vga_plot;
`ifdef MANDELBROT_JULIA_EN
  logic                julia;
  logic signed [W-1:0] jc_re;
  logic signed [W-1:0] jc_im;
`endif

  mandelbrot_engine #(
    .WIDTH(W), .FRAC(22), .SCREEN_W(SW), .SCREEN_H(SH), .MAX_ITER(MI),
    .COLOUR_BITS(3), .XW(9), .YW(8)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .x_origin(x_origin), .y_origin(y_origin), .step(step),
    .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
`ifdef MANDELBROT_JULIA_EN
    , .julia(julia), .jc_re(jc_re), .jc_im(jc_im)
`endif
  );

  typedef struct {
    int x;
    int y;
    int colour;
    int off;
  } exp_t;

  exp_t q[$];
  int   vectors;
  int   miscompares;
  int   cyc;
  int   accept_cyc;
  int   last_off;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic void model(input int cx, input int cy, input int jr, input int ji,
                                input bit jul, output int nf, output bit esc);
    longint a, b, aa, bb, ab2, ar, ai;
    a  = cx;
    b  = cy;
    ar = jul ? jr : cx;
    ai = jul ? ji : cy;
    nf  = 0;
    esc = 0;
    for (int n = 0; n <= MI; n++) begin
      aa  = (a * a) >>> 22;
      bb  = (b * b) >>> 22;
      ab2 = (a * b) >>> 21;
      nf  = n;
      if (aa + bb > 64'sd16777216) begin
        esc = 1;
        break;
      end
      if (n == MI) break;
      a = longint'(int'(aa - bb + ar));
      b = longint'(int'(ab2 + ai));
    end
  endfunction

  function automatic void push_frame(input int x0, input int y0, input int st,
                                     input bit jul, input int jr, input int ji);
    int   cx, cy, nf, off;
    bit   esc;
    exp_t e;
    off = -1;
    cy  = y0;
    for (int j = 0; j < SH; j++) begin
      cx = x0;
      for (int i = 0; i < SW; i++) begin
        model(cx, cy, jr, ji, jul, nf, esc);
        off      = off + nf + 3;
        e.x      = i;
        e.y      = j;
        e.colour = esc ? (nf & 7) : 0;
        e.off    = off;
        q.push_back(e);
        cx = cx + st;
      end
      cy = cy + st;
    end
    last_off = off;
  endfunction

  always @(negedge clk) begin
    if (rstn === 1'b1 && vga_plot === 1'b1) begin
      chk("plot_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("plot_x", 64'(vga_x), 64'(e.x));
        chk("plot_y", 64'(vga_y), 64'(e.y));
        chk("plot_colour", 64'(vga_colour), 64'(e.colour));
        chk("plot_cycle", 64'(cyc - accept_cyc), 64'(e.off));
      end
    end
  end

  task automatic start_frame(input int x0, input int y0, input int st,
                             input bit jul, input int jr, input int ji, input bit hold);
    @(negedge clk);
    x_origin = x0;
    y_origin = y0;
    step     = st;
`ifdef MANDELBROT_JULIA_EN
    julia = jul;
    jc_re = jr;
    jc_im = ji;
`endif
    start = 1'b1;
    push_frame(x0, y0, st, jul, jr, ji);
    @(posedge clk);
    #1 accept_cyc = cyc;
    x_origin = $urandom;
    y_origin = $urandom;
    step     = $urandom;
`ifdef MANDELBROT_JULIA_EN
    julia = $urandom_range(1);
    jc_re = $urandom;
    jc_im = $urandom;
`endif
    if (!hold) start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_done_cycle"}, 64'(cyc - accept_cyc), 64'(last_off + 1));
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    chk({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_plot"}, 64'(vga_plot), 64'd0);
    chk({tag, "_x"}, 64'(vga_x), 64'd0);
    chk({tag, "_y"}, 64'(vga_y), 64'd0);
    chk({tag, "_colour"}, 64'(vga_colour), 64'd0);
  endtask

  initial begin
    clk = 1'b0;
    cyc = 0;
    accept_cyc = 0;
    last_off = 0;
    vectors = 0;
    miscompares = 0;
    rstn = 1'b0;
    start = 1'b0;
    x_origin = '0;
    y_origin = '0;
    step = '0;
`ifdef MANDELBROT_JULIA_EN
    julia = 1'b0;
    jc_re = '0;
    jc_im = '0;
`endif
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;

    // Frame A: c=0 runs to the limit, c=2 escapes at n=1; a stray start pulse mid-ITER is ignored
    start_frame(0, 0, 2 * ONE, 1'b0, 0, 0, 1'b0);
    repeat (4) @(negedge clk);
    x_origin = 3 * ONE;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("frameA");
    @(negedge clk);
    chk("frameA_done_cleared", 64'(done), 64'd0);

    // Frame B: every pixel escapes at once; start held high must not retrigger
    start_frame(3 * ONE, 0, ONE / 4, 1'b0, 0, 0, 1'b1);
    wait_done("frameB");
    repeat (4) begin
      @(negedge clk);
      chk("frameB_done_held", 64'(done), 64'd1);
      chk("frameB_no_restart", 64'(busy), 64'd0);
    end
    start = 1'b0;
    @(negedge clk);
    chk("frameB_done_cleared", 64'(done), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("frameB_idle", 64'(busy), 64'd0);
    end

    // Reset during ITER of the first pixel clears every output on the next cycle
    start_frame(0, 0, 2 * ONE, 1'b0, 0, 0, 1'b0);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk_all_zero("midframe_reset");
    q.delete();
    rstn = 1'b1;

    // Frame C: a coarse slice of the classic view with mixed escape counts
    start_frame(-2 * ONE, -(3 * ONE) / 2, (3 * ONE) / 4, 1'b0, 0, 0, 1'b0);
    wait_done("frameC");

`ifdef MANDELBROT_JULIA_EN
    start_frame(ONE / 2, 0, ONE / 4, 1'b1, 0, 0, 1'b0);
    wait_done("juliaA");
    start_frame((3 * ONE) / 2, 0, ONE / 4, 1'b1, 0, 0, 1'b0);
    wait_done("juliaB");
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
